// File: rtl/writeback_if.sv
// Writeback stage bus: instruction fields from memory access, decode read ports,
// and the writeback/forwarding tap.
interface writeback_if;
   logic        in_noop;
   logic [6:0]  in_opcode;
   logic [2:0]  in_funct3;
   logic [4:0]  in_rd;
   logic [31:0] in_res;
   logic [31:0] in_pc;
   logic [31:0] in_mem_rd;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic        wb_en;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   modport master (
      output in_noop, in_opcode, in_funct3, in_rd, in_res, in_pc, in_mem_rd,
      output rs1_addr, rs2_addr,
      input  rs1_data, rs2_data, wb_en, wb_rd, wb_data
   );

   modport slave (
      input  in_noop, in_opcode, in_funct3, in_rd, in_res, in_pc, in_mem_rd,
      input  rs1_addr, rs2_addr,
      output rs1_data, rs2_data, wb_en, wb_rd, wb_data
   );
endinterface

// File: rtl/writeback.sv
// RV32I writeback stage: aligns control with the late memory word, sizes loads,
// selects the writeback value and owns the integer register file with bypassed reads.
module writeback #(
   parameter int unsigned NUM_REGS  = 32,
   parameter logic [31:0] RESET_VAL = 32'h0
) (
   input logic        clk,
   input logic        rst,
   writeback_if.slave bus
);

   localparam int unsigned XLEN   = 32;
   localparam int unsigned REG_AW = 5;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   logic              s_noop;
   logic [6:0]        s_opcode;
   logic [2:0]        s_funct3;
   logic [REG_AW-1:0] s_rd;
   logic [XLEN-1:0]   s_res;
   logic [XLEN-1:0]   s_pc;

   logic [XLEN-1:0]   load_val;
   logic              load_ok;
   logic [XLEN-1:0]   sel_val;
   logic              writes;

   logic [XLEN-1:0]   regs [NUM_REGS];

   // Stage register: holds control one cycle so it meets the memory read word.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_noop   <= 1'b1;
         s_opcode <= '0;
         s_funct3 <= '0;
         s_rd     <= '0;
         s_res    <= '0;
         s_pc     <= '0;
      end else begin
         s_noop   <= bus.in_noop;
         s_opcode <= bus.in_opcode;
         s_funct3 <= bus.in_funct3;
         s_rd     <= bus.in_rd;
         s_res    <= bus.in_res;
         s_pc     <= bus.in_pc;
      end
   end

   always_comb begin
      load_val = '0;
      load_ok  = 1'b1;
      case (s_funct3)
         3'd0:    load_val = {{24{bus.in_mem_rd[7]}},  bus.in_mem_rd[7:0]};
         3'd1:    load_val = {{16{bus.in_mem_rd[15]}}, bus.in_mem_rd[15:0]};
         3'd2:    load_val = bus.in_mem_rd;
         3'd4:    load_val = {24'h0, bus.in_mem_rd[7:0]};
         3'd5:    load_val = {16'h0, bus.in_mem_rd[15:0]};
         default: load_ok  = 1'b0;
      endcase
   end

   // Non-writing opcodes fall through to s_res so the tap reads 0 out of reset.
   always_comb begin
      writes  = 1'b0;
      sel_val = s_res;
      case (s_opcode)
         OPC_LOAD: begin
            writes  = load_ok;
            sel_val = load_val;
         end
         OPC_JAL, OPC_JALR: begin
            writes  = 1'b1;
            sel_val = s_pc + XLEN'(4);
         end
         OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: writes = 1'b1;
         default: writes = 1'b0;
      endcase
   end

   assign bus.wb_en   = !rst && !s_noop && writes && (s_rd != '0);
   assign bus.wb_rd   = s_rd;
   assign bus.wb_data = sel_val;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs[i] <= RESET_VAL;
         end
      end else if (bus.wb_en) begin
         regs[bus.wb_rd] <= bus.wb_data;
      end
   end

   // Reads see the write landing this cycle so decode needs no extra stall.
   assign bus.rs1_data = (bus.rs1_addr == '0) ? '0 :
                         (bus.wb_en && (bus.wb_rd == bus.rs1_addr)) ? bus.wb_data :
                         regs[bus.rs1_addr];
   assign bus.rs2_data = (bus.rs2_addr == '0) ? '0 :
                         (bus.wb_en && (bus.wb_rd == bus.rs2_addr)) ? bus.wb_data :
                         regs[bus.rs2_addr];

endmodule

// File: tb/tb_writeback.sv
// Scoreboard bench for writeback: directed spec cases plus random traffic checked
// against an architectural register-file model.
module tb_writeback;

   localparam logic [31:0] RV = 32'hA5A5_0F0F;

   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] SYSTEM = 7'b1110011;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] OPIMM  = 7'b0010011;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;

   typedef struct {
      logic        noop;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [4:0]  rd;
      logic [31:0] res;
      logic [31:0] pc;
   } instr_t;

   typedef struct {
      logic        en;
      logic [4:0]  rd;
      logic [31:0] data;
      logic [31:0] r1;
      logic [31:0] r2;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   writeback_if bus ();

   writeback #(.NUM_REGS(32), .RESET_VAL(RV)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   exp_t        sb[$];
   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] mregs [32];
   instr_t      pend;
   instr_t      nop_i;

   function automatic instr_t mk(input logic noop, input logic [6:0] op, input logic [2:0] f3,
                                 input logic [4:0] rd, input logic [31:0] res, input logic [31:0] pc);
      instr_t t;
      t.noop = noop; t.op = op; t.f3 = f3; t.rd = rd; t.res = res; t.pc = pc;
      return t;
   endfunction

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      vectors++;
      if (act !== exp_v) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
      end
   endfunction

   // Architectural result of a retiring instruction given its memory word.
   function automatic void ref_wb(input instr_t i, input logic [31:0] mem,
                                  output logic en, output logic [31:0] d);
      int v;
      en = 1'b0;
      d  = 32'h0;
      if (i.op == LOAD) begin
         case (i.f3)
            3'd0: begin v = int'(mem & 32'hFF);   if (v > 127)   v -= 256;   d = 32'(v); en = 1'b1; end
            3'd1: begin v = int'(mem & 32'hFFFF); if (v > 32767) v -= 65536; d = 32'(v); en = 1'b1; end
            3'd2: begin d = mem; en = 1'b1; end
            3'd4: begin d = mem & 32'hFF;   en = 1'b1; end
            3'd5: begin d = mem & 32'hFFFF; en = 1'b1; end
            default: en = 1'b0;
         endcase
      end else if (i.op == JAL || i.op == JALR) begin
         d  = i.pc + 32'd4;
         en = 1'b1;
      end else if (i.op == OP || i.op == OPIMM || i.op == LUI || i.op == AUIPC) begin
         d  = i.res;
         en = 1'b1;
      end
      if (i.noop || i.rd == 5'd0) en = 1'b0;
   endfunction

   function automatic logic [31:0] rd_model(input logic [4:0] a, input logic en,
                                           input logic [4:0] rd, input logic [31:0] d);
      if (a == 5'd0) return 32'h0;
      if (en && rd == a) return d;
      return mregs[a];
   endfunction

   // One cycle: drive inputs, push the expected response for the retiring instruction.
   task automatic step(input instr_t nxt, input logic [31:0] mem, input logic [4:0] a1,
                       input logic [4:0] a2, input logic r,
                       output logic mid_en, output logic [31:0] mid_r1);
      exp_t        e;
      logic        en;
      logic [31:0] d;
      bus.in_noop   = nxt.noop;
      bus.in_opcode = nxt.op;
      bus.in_funct3 = nxt.f3;
      bus.in_rd     = nxt.rd;
      bus.in_res    = nxt.res;
      bus.in_pc     = nxt.pc;
      bus.in_mem_rd = mem;
      bus.rs1_addr  = a1;
      bus.rs2_addr  = a2;
      rst           = r;
      ref_wb(pend, mem, en, d);
      if (r) en = 1'b0;
      e.en   = en;
      e.rd   = pend.rd;
      e.data = d;
      e.r1   = rd_model(a1, en, pend.rd, d);
      e.r2   = rd_model(a2, en, pend.rd, d);
      sb.push_back(e);
      if (r) begin
         for (int k = 0; k < 32; k++) mregs[k] = RV;
         pend = nop_i;
      end else begin
         if (en) mregs[pend.rd] = d;
         pend = nxt;
      end
      #2;
      mid_en = bus.wb_en;
      mid_r1 = bus.rs1_data;
      @(posedge clk);
      #1;
   endtask

   // Issue, retire with a bypass read, then read back from the regfile.
   task automatic dir(input string name, input instr_t i, input logic [31:0] mem,
                      input logic [4:0] rd, input logic exp_en, input logic [31:0] exp_val);
      logic        e;
      logic [31:0] v;
      step(i, 32'h0, 5'd0, 5'd0, 1'b0, e, v);
      step(nop_i, mem, rd, rd, 1'b0, e, v);
      chk({name, "_en"}, 32'(e), 32'(exp_en));
      chk({name, "_bypass"}, v, exp_val);
      step(nop_i, 32'h0, rd, 5'd0, 1'b0, e, v);
      chk({name, "_reg"}, v, exp_val);
   endtask

   // Monitor: compare every cycle that has a pending expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("wb_en", 32'(bus.wb_en), 32'(e.en));
            if (e.en) begin
               chk("wb_rd", 32'(bus.wb_rd), 32'(e.rd));
               chk("wb_data", bus.wb_data, e.data);
            end
            chk("rs1_data", bus.rs1_data, e.r1);
            chk("rs2_data", bus.rs2_data, e.r2);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        e;
      logic [31:0] v;
      logic [6:0]  ops [11];
      instr_t      ri;
      logic [4:0]  a1, a2;

      ops = '{LOAD, LOAD, STORE, BRANCH, SYSTEM, JAL, JALR, OP, OPIMM, LUI, AUIPC};
      nop_i = mk(1'b1, 7'h0, 3'd0, 5'd0, 32'h0, 32'h0);

      rst           = 1'b1;
      bus.in_noop   = 1'b1;
      bus.in_opcode = 7'h0;
      bus.in_funct3 = 3'd0;
      bus.in_rd     = 5'd0;
      bus.in_res    = 32'h0;
      bus.in_pc     = 32'h0;
      bus.in_mem_rd = 32'h0;
      bus.rs1_addr  = 5'd5;
      bus.rs2_addr  = 5'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_wb_en", 32'(bus.wb_en), 32'h0);
      chk("reset_wb_rd", 32'(bus.wb_rd), 32'h0);
      chk("reset_wb_data", bus.wb_data, 32'h0);
      chk("reset_rs1_x5", bus.rs1_data, RV);
      chk("reset_rs2_x0", bus.rs2_data, 32'h0);
      for (int k = 0; k < 32; k++) mregs[k] = RV;
      pend = nop_i;

      dir("lw",     mk(1'b0, LOAD,  3'd2, 5'd5,  32'h1000,     32'h0),        32'hDEADBEEF, 5'd5,  1'b1, 32'hDEADBEEF);
      dir("lb",     mk(1'b0, LOAD,  3'd0, 5'd6,  32'h1004,     32'h0),        32'h000000F0, 5'd6,  1'b1, 32'hFFFFFFF0);
      dir("lbu",    mk(1'b0, LOAD,  3'd4, 5'd7,  32'h1008,     32'h0),        32'h000000F0, 5'd7,  1'b1, 32'h000000F0);
      dir("lh",     mk(1'b0, LOAD,  3'd1, 5'd8,  32'h100C,     32'h0),        32'h00008001, 5'd8,  1'b1, 32'hFFFF8001);
      dir("lhu",    mk(1'b0, LOAD,  3'd5, 5'd10, 32'h1010,     32'h0),        32'h00008001, 5'd10, 1'b1, 32'h00008001);
      dir("op",     mk(1'b0, OP,    3'd0, 5'd3,  32'h7,        32'h0),        32'h0,        5'd3,  1'b1, 32'h7);
      dir("jal",    mk(1'b0, JAL,   3'd0, 5'd1,  32'h0,        32'hFFFFFFFC), 32'h0,        5'd1,  1'b1, 32'h0);
      dir("jalr",   mk(1'b0, JALR,  3'd0, 5'd2,  32'h0,        32'h100),      32'h0,        5'd2,  1'b1, 32'h104);
      dir("lui",    mk(1'b0, LUI,   3'd0, 5'd4,  32'h12345000, 32'h0),        32'h0,        5'd4,  1'b1, 32'h12345000);
      dir("auipc",  mk(1'b0, AUIPC, 3'd0, 5'd11, 32'h7FFFF000, 32'h0),        32'h0,        5'd11, 1'b1, 32'h7FFFF000);
      dir("opimm",  mk(1'b0, OPIMM, 3'd0, 5'd12, 32'hFFFFFFFF, 32'h0),        32'h0,        5'd12, 1'b1, 32'hFFFFFFFF);
      dir("x0",     mk(1'b0, OP,    3'd0, 5'd0,  32'h55,       32'h0),        32'h0,        5'd0,  1'b0, 32'h0);
      dir("store",  mk(1'b0, STORE, 3'd2, 5'd5,  32'h1,        32'h0),        32'h0,        5'd5,  1'b0, 32'hDEADBEEF);
      dir("branch", mk(1'b0, BRANCH,3'd0, 5'd5,  32'h2,        32'h0),        32'h0,        5'd5,  1'b0, 32'hDEADBEEF);
      dir("noop",   mk(1'b1, OP,    3'd0, 5'd5,  32'h3,        32'h0),        32'h0,        5'd5,  1'b0, 32'hDEADBEEF);
      dir("ld_f3_3",mk(1'b0, LOAD,  3'd3, 5'd5,  32'h0,        32'h0),        32'h12345678, 5'd5,  1'b0, 32'hDEADBEEF);
      dir("ld_f3_6",mk(1'b0, LOAD,  3'd6, 5'd5,  32'h0,        32'h0),        32'h12345678, 5'd5,  1'b0, 32'hDEADBEEF);
      dir("ld_f3_7",mk(1'b0, LOAD,  3'd7, 5'd5,  32'h0,        32'h0),        32'h12345678, 5'd5,  1'b0, 32'hDEADBEEF);

      // Reset while a write to x9 sits in the stage register.
      dir("x9", mk(1'b0, OP, 3'd0, 5'd9, 32'hAA, 32'h0), 32'h0, 5'd9, 1'b1, 32'hAA);
      step(mk(1'b0, OP, 3'd0, 5'd9, 32'hBB, 32'h0), 32'h0, 5'd9, 5'd0, 1'b0, e, v);
      step(nop_i, 32'h0, 5'd9, 5'd9, 1'b1, e, v);
      chk("rst_cycle_en", 32'(e), 32'h0);
      chk("rst_cycle_x9", v, 32'hAA);
      step(nop_i, 32'h0, 5'd9, 5'd0, 1'b0, e, v);
      chk("rst_after_en", 32'(e), 32'h0);
      chk("rst_after_x9", v, RV);
      step(nop_i, 32'h0, 5'd9, 5'd0, 1'b0, e, v);
      chk("rst_dropped_x9", v, RV);

      for (int n = 0; n < 600; n++) begin
         ri = mk(($urandom_range(0, 9) == 0), ops[$urandom_range(0, 10)], 3'($urandom_range(0, 7)),
                 5'($urandom_range(0, 31)), $urandom, $urandom);
         if ($urandom_range(0, 15) == 0) ri.op = 7'($urandom);
         a1 = ($urandom_range(0, 1) == 0) ? pend.rd : 5'($urandom_range(0, 31));
         a2 = ($urandom_range(0, 2) == 0) ? a1 : 5'($urandom_range(0, 31));
         step(ri, $urandom, a1, a2, ($urandom_range(0, 99) == 0), e, v);
      end
      step(nop_i, $urandom, 5'd1, 5'd2, 1'b0, e, v);
      step(nop_i, 32'h0, 5'd3, 5'd4, 1'b0, e, v);

      chk("sb_drain", 32'(sb.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
